// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared FIR output-path defaults and saturation limits
package fir_pkg;

  localparam int W_IN_DEF  = 32;
  localparam int W_OUT_DEF = 16;
  localparam int DEPTH_DEF = 8;

  localparam int SAT_MAX = (1 << (W_OUT_DEF - 1)) - 1;
  localparam int SAT_MIN = -(1 << (W_OUT_DEF - 1));

endpackage

// File: rtl/fir_sync_fifo.sv
// rtl/fir_sync_fifo.sv - synchronous FIFO with occupancy count and flush
module fir_sync_fifo
  import fir_pkg::*;
#(
  parameter int W     = W_OUT_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                       CLK,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               data_in,
  output logic [W-1:0]               data_out,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [W-1:0]  r_mem [DEPTH];

  logic w_pop;
  logic w_push;

  // Flags come from the occupancy count so wrapped pointers never alias full and empty.
  assign empty    = (r_count == '0);
  assign full     = (r_count == (AW+1)'(DEPTH));
  assign count    = r_count;
  assign data_out = r_mem[r_rd_ptr];

  assign w_pop  = pop && !empty;
  assign w_push = push && (!full || w_pop);

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
    end
  end

  always_ff @(posedge CLK) begin
    if (w_push && !clr) r_mem[r_wr_ptr] <= data_in;
  end

endmodule

// File: rtl/fir_out_buffer.sv
// rtl/fir_out_buffer.sv - FIR result requantiser, saturator and output FIFO
module fir_out_buffer
  import fir_pkg::*;
#(
  parameter int W_IN  = W_IN_DEF,
  parameter int W_OUT = W_OUT_DEF,
  parameter int SHIFT = 0,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                       CLK,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [W_IN-1:0]            in_data,
  input  logic                       clr,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [W_OUT-1:0]           out_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       ovf,
  output logic                       sat
);

  localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [W_IN:0] RND = (SHIFT > 0) ? ((W_IN+1)'(1) << RSH) : '0;
  localparam logic signed [W_IN:0] LIM_HI = {{(W_IN-W_OUT+2){1'b0}}, {(W_OUT-1){1'b1}}};
  localparam logic signed [W_IN:0] LIM_LO = {{(W_IN-W_OUT+2){1'b1}}, {(W_OUT-1){1'b0}}};

  logic signed [W_IN:0] w_ext;
  logic signed [W_IN:0] w_shr;
  logic                 w_hi;
  logic                 w_lo;
  logic [W_OUT-1:0]     w_q;
  logic                 w_pop;
  logic                 w_push;
  logic                 w_full;
  logic                 w_empty;

  logic                 r_s1_v;
  logic [W_OUT-1:0]     r_s1_d;
  logic                 r_ovf;
  logic                 r_sat;

  // One guard bit keeps the rounding add from wrapping at the positive extreme.
  assign w_ext = $signed({in_data[W_IN-1], in_data}) + RND;
  assign w_shr = w_ext >>> SHIFT;
  assign w_hi  = (w_shr > LIM_HI);
  assign w_lo  = (w_shr < LIM_LO);
  assign w_q   = w_hi ? LIM_HI[W_OUT-1:0] : (w_lo ? LIM_LO[W_OUT-1:0] : w_shr[W_OUT-1:0]);

  assign out_valid = !w_empty;
  assign full      = w_full;
  assign ovf       = r_ovf;
  assign sat       = r_sat;
  assign w_pop     = out_valid && out_ready;
  assign w_push    = r_s1_v && (!w_full || w_pop);

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      r_s1_v <= 1'b0;
      r_ovf  <= 1'b0;
      r_sat  <= 1'b0;
    end else if (clr) begin
      r_s1_v <= 1'b0;
      r_ovf  <= 1'b0;
      r_sat  <= 1'b0;
    end else begin
      r_s1_v <= in_valid;
      if (in_valid && (w_hi || w_lo)) r_sat <= 1'b1;
      // Upstream free-runs, so a full FIFO without a pop loses the sample.
      if (r_s1_v && w_full && !w_pop) r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (in_valid) r_s1_d <= w_q;
  end

  fir_sync_fifo #(
    .W     (W_OUT),
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK      (CLK),
    .rst      (rst),
    .clr      (clr),
    .push     (w_push),
    .pop      (w_pop),
    .data_in  (r_s1_d),
    .data_out (out_data),
    .count    (count),
    .full     (w_full),
    .empty    (w_empty)
  );

endmodule

// File: tb/tb_fir_out_buffer.sv
// tb/tb_fir_out_buffer.sv - randomized and directed bench for fir_out_buffer
module tb_fir_out_buffer;
  import fir_pkg::*;

  localparam int DEPTH = 8;

  logic        CLK = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic        clr;
  logic        out_ready;

  logic        ov    [2];
  logic [15:0] od    [2];
  logic [3:0]  cnt   [2];
  logic        fl    [2];
  logic        ovf_o [2];
  logic        sat_o [2];

  int     n_checks = 0;
  int     n_fail   = 0;
  longint mq [2][$];
  longint ms1d [2];
  bit     ms1v;
  bit     movf [2];
  bit     msat [2];
  int     shv  [2];

  always #5 CLK = ~CLK;

  fir_out_buffer #(.SHIFT(0)) u_dut0 (
    .CLK(CLK), .rst(rst), .in_valid(in_valid), .in_data(in_data), .clr(clr),
    .out_ready(out_ready), .out_valid(ov[0]), .out_data(od[0]), .count(cnt[0]),
    .full(fl[0]), .ovf(ovf_o[0]), .sat(sat_o[0])
  );

  fir_out_buffer #(.SHIFT(4)) u_dut4 (
    .CLK(CLK), .rst(rst), .in_valid(in_valid), .in_data(in_data), .clr(clr),
    .out_ready(out_ready), .out_valid(ov[1]), .out_data(od[1]), .count(cnt[1]),
    .full(fl[1]), .ovf(ovf_o[1]), .sat(sat_o[1])
  );

  task automatic chk(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic longint requant(input longint y, input int sh);
    if (sh == 0) return y;
    return (y + (longint'(1) << (sh - 1))) >>> sh;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      mq[k].delete();
      movf[k] = 1'b0;
      msat[k] = 1'b0;
    end
    ms1v = 1'b0;
  endtask

  task automatic model_edge(input bit iv, input longint d, input bit rdy, input bit c);
    longint y;
    longint v;
    bit     do_pop;
    y = longint'($signed(d[31:0]));
    if (c) begin
      model_clear();
      return;
    end
    for (int k = 0; k < 2; k++) begin
      do_pop = (mq[k].size() > 0) && rdy;
      if (do_pop) void'(mq[k].pop_front());
      if (ms1v) begin
        if (mq[k].size() < DEPTH) mq[k].push_back(ms1d[k]);
        else movf[k] = 1'b1;
      end
      if (iv) begin
        v = requant(y, shv[k]);
        if (v > SAT_MAX) begin v = SAT_MAX; msat[k] = 1'b1; end
        if (v < SAT_MIN) begin v = SAT_MIN; msat[k] = 1'b1; end
        ms1d[k] = v;
      end
    end
    ms1v = iv;
  endtask

  task automatic check_all();
    int sz;
    for (int k = 0; k < 2; k++) begin
      sz = mq[k].size();
      chk($sformatf("u%0d.out_valid", k), longint'(ov[k]), longint'(sz != 0));
      chk($sformatf("u%0d.count", k), longint'(cnt[k]), longint'(sz));
      chk($sformatf("u%0d.full", k), longint'(fl[k]), longint'(sz == DEPTH));
      chk($sformatf("u%0d.ovf", k), longint'(ovf_o[k]), longint'(movf[k]));
      chk($sformatf("u%0d.sat", k), longint'(sat_o[k]), longint'(msat[k]));
      if (sz != 0) chk($sformatf("u%0d.out_data", k), longint'($signed(od[k])), mq[k][0]);
    end
  endtask

  task automatic cycle(input bit iv, input longint d, input bit rdy, input bit c);
    in_valid  = iv;
    in_data   = d[31:0];
    out_ready = rdy;
    clr       = c;
    @(posedge CLK);
    model_edge(iv, d, rdy, c);
    #1;
    check_all();
  endtask

  longint v036 [4];
  longint e036 [4];
  longint v037 [4];
  longint e037 [4];
  longint d;

  initial begin
    shv[0] = 0;
    shv[1] = 4;
    v036 = '{-32, 15, 40000, -40000};
    e036 = '{longint'(16'hFFE0), longint'(16'h000F), longint'(16'h7FFF), longint'(16'h8000)};
    v037 = '{24, -24, 7, -9};
    e037 = '{2, -1, 0, -1};
    model_clear();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; clr = 1'b0; out_ready = 1'b0;
    #12;
    for (int k = 0; k < 2; k++) begin
      chk("reset.out_valid", longint'(ov[k]), 0);
      chk("reset.count", longint'(cnt[k]), 0);
      chk("reset.full", longint'(fl[k]), 0);
      chk("reset.ovf", longint'(ovf_o[k]), 0);
      chk("reset.sat", longint'(sat_o[k]), 0);
    end
    rst = 1'b0;

    // requantisation with SHIFT=0 and saturation
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, v036[i], 1'b0, 1'b0);
      if (i == 2) begin
        cycle(1'b0, 0, 1'b0, 1'b0);
        chk("sat_after_third", longint'(sat_o[0]), 1);
      end
    end
    cycle(1'b0, 0, 1'b0, 1'b0);
    cycle(1'b0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("shift0.vector", longint'(od[0]), e036[i]);
      cycle(1'b0, 0, 1'b1, 1'b0);
    end

    // rounding with SHIFT=4
    cycle(1'b0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b1, v037[i], 1'b0, 1'b0);
    cycle(1'b0, 0, 1'b0, 1'b0);
    cycle(1'b0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("shift4.vector", longint'($signed(od[1])), e037[i]);
      cycle(1'b0, 0, 1'b1, 1'b0);
    end

    // overflow: nine inputs into a stalled FIFO
    cycle(1'b0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) cycle(1'b1, 100 * i + 1, 1'b0, 1'b0);
    cycle(1'b0, 0, 1'b0, 1'b0);
    chk("ovf.count", longint'(cnt[0]), 8);
    chk("ovf.full", longint'(fl[0]), 1);
    chk("ovf.flag", longint'(ovf_o[0]), 1);
    for (int i = 0; i < 8; i++) begin
      chk("ovf.order", longint'($signed(od[0])), 100 * i + 1);
      cycle(1'b0, 0, 1'b1, 1'b0);
    end
    chk("ovf.drained", longint'(ov[0]), 0);

    // simultaneous push and pop while full
    cycle(1'b0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) cycle(1'b1, 10 + i, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 50 + i, 1'b1, 1'b0);
      chk("fullpp.count", longint'(cnt[0]), 8);
      chk("fullpp.ovf", longint'(ovf_o[0]), 0);
    end

    // asynchronous reset pulse mid-stream
    cycle(1'b0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b1, 20 + i, 1'b0, 1'b0);
    cycle(1'b0, 0, 1'b0, 1'b0);
    chk("prerst.count", longint'(cnt[0]), 5);
    cycle(1'b1, 77, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("rst.out_valid", longint'(ov[0]), 0);
    chk("rst.count", longint'(cnt[0]), 0);
    chk("rst.count4", longint'(cnt[1]), 0);
    rst = 1'b0;
    model_clear();
    cycle(1'b1, 3, 1'b1, 1'b0);
    cycle(1'b0, 0, 1'b1, 1'b0);
    chk("postrst.out_valid", longint'(ov[0]), 1);
    chk("postrst.out_data", longint'($signed(od[0])), 3);
    cycle(1'b0, 0, 1'b1, 1'b0);

    // flush with a concurrent input
    for (int i = 0; i < 3; i++) cycle(1'b1, 30 + i, 1'b0, 1'b0);
    cycle(1'b1, 100000, 1'b0, 1'b0);
    cycle(1'b0, 0, 1'b0, 1'b0);
    chk("preclr.count", longint'(cnt[0]), 4);
    chk("preclr.sat", longint'(sat_o[0]), 1);
    cycle(1'b1, 55, 1'b1, 1'b1);
    chk("clr.count", longint'(cnt[0]), 0);
    chk("clr.ovf", longint'(ovf_o[0]), 0);
    chk("clr.sat", longint'(sat_o[0]), 0);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 0, 1'b1, 1'b0);
      chk("clr.nothing", longint'(ov[0]), 0);
    end

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 3))
        0:       d = longint'($signed($urandom()));
        1:       d = longint'($urandom_range(0, 200000)) - 100000;
        default: d = longint'($urandom_range(0, 64)) - 32;
      endcase
      cycle(($urandom_range(0, 3) != 0), d, ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 79) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
